// File: rtl/testeio_mem_pkg.sv
// Shared types and helpers for the testeio dual-port RAM: FSM state encoding,
// byte-enable width and the byte-wise merge used for write forwarding.
package testeio_mem_pkg;

  typedef enum logic {ST_INIT, ST_READY} mem_state_e;

  // Widest word be_merge can handle; callers size-cast to and from it.
  localparam int MERGE_W    = 512;
  localparam int MERGE_BE_W = MERGE_W / 8;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]    old_word,
    input logic [MERGE_W-1:0]    new_word,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MERGE_BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/testeio_dual_port_ram_pl_if.sv
// Avalon-MM slave bundle for one RAM port; the RAM takes two of these.
interface testeio_dual_port_ram_pl_if
  import testeio_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  localparam int BE_W = be_width(DATA_W);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/testeio_mem_rd_pipe.sv
// Per-port read return pipeline: merges forwarded write bytes into the array
// word at stage 0, then delays data/valid to the configured read latency.
module testeio_mem_rd_pipe
  import testeio_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rd_acc,
  input  logic [DATA_W-1:0]           mem_q,
  input  logic [DATA_W-1:0]           fwd_data,
  input  logic [be_width(DATA_W)-1:0] fwd_be,
  output logic [DATA_W-1:0]           readdata,
  output logic                        readdatavalid
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  // Stage 0: capture array word with same-cycle writer bytes forwarded in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) begin
        data_p0 <= DATA_W'(be_merge(MERGE_W'(mem_q), MERGE_W'(fwd_data),
                                    MERGE_BE_W'(fwd_be)));
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              vld_p1;
      logic [DATA_W-1:0] data_p1;

      // Stage 1: extra register; data only advances with a valid so the output holds
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign readdata      = data_p1;
      assign readdatavalid = vld_p1;
    end else begin : g_lat1
      assign readdata      = data_p0;
      assign readdatavalid = vld_p0;
    end
  endgenerate

endmodule

// File: rtl/testeio_dual_port_ram_pl.sv
// True dual-port RAM with two Avalon-MM slaves on one clock: power-up clear,
// write/write collision stall on s2, and cross-port read-during-write forwarding.
module testeio_dual_port_ram_pl
  import testeio_mem_pkg::*;
#(
  parameter int              DATA_W        = 32,
  parameter int              ADDR_W        = 14,
  parameter int              READ_LATENCY  = 1,
  parameter int              INIT_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  testeio_dual_port_ram_pl_if.slave   s1,
  testeio_dual_port_ram_pl_if.slave   s2,
  output logic                        init_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = be_width(DATA_W);

  generate
    if ((DATA_W % 8) != 0 || DATA_W > MERGE_W ||
        (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_param_check
      $fatal(1, "testeio_dual_port_ram_pl: DATA_W must be a multiple of 8 and READ_LATENCY 1 or 2");
    end
  endgenerate

  mem_state_e        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              in_init;

  // Clear walks every address once; the last write hands over to READY
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      clr_addr  <= '0;
      init_done <= (INIT_ON_RESET == 0);
    end else if (state == ST_INIT) begin
      clr_addr <= clr_addr + 1'b1;
      if (&clr_addr) begin
        state     <= ST_READY;
        init_done <= 1'b1;
      end
    end
  end

  assign in_init = (state == ST_INIT);

  logic wr_coll;
  logic acc1, acc2;
  logic wr1, wr2;
  logic rd1, rd2;

  // s1 wins a same-address write/write; s2 retries and lands last
  assign wr_coll = s1.chipselect & s1.write & s2.chipselect & s2.write &
                   (s1.address == s2.address);

  assign s1.waitrequest = in_init;
  assign s2.waitrequest = in_init | wr_coll;

  assign acc1 = s1.chipselect & (s1.read | s1.write) & ~s1.waitrequest;
  assign acc2 = s2.chipselect & (s2.read | s2.write) & ~s2.waitrequest;
  assign wr1  = acc1 & s1.write;
  assign wr2  = acc2 & s2.write;
  assign rd1  = acc1 & s1.read & ~s1.write;
  assign rd2  = acc2 & s2.read & ~s2.write;

  logic [BE_W-1:0] fwd_be1, fwd_be2;

  assign fwd_be1 = (wr2 && (s2.address == s1.address)) ? s2.byteenable : '0;
  assign fwd_be2 = (wr1 && (s1.address == s2.address)) ? s1.byteenable : '0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q1, mem_q2;

  always_ff @(posedge clk) begin
    if (in_init) begin
      mem[clr_addr] <= INIT_VALUE;
    end else begin
      if (wr1) begin
        for (int b = 0; b < BE_W; b++) begin
          if (s1.byteenable[b]) mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
        end
      end
      if (wr2) begin
        for (int b = 0; b < BE_W; b++) begin
          if (s2.byteenable[b]) mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
        end
      end
    end
  end

  assign mem_q1 = mem[s1.address];
  assign mem_q2 = mem[s2.address];

  testeio_mem_rd_pipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe_s1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_acc        (rd1),
    .mem_q         (mem_q1),
    .fwd_data      (s2.writedata),
    .fwd_be        (fwd_be1),
    .readdata      (s1.readdata),
    .readdatavalid (s1.readdatavalid)
  );

  testeio_mem_rd_pipe #(
    .DATA_W       (DATA_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe_s2 (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_acc        (rd2),
    .mem_q         (mem_q2),
    .fwd_data      (s1.writedata),
    .fwd_be        (fwd_be2),
    .readdata      (s2.readdata),
    .readdatavalid (s2.readdatavalid)
  );

endmodule

// File: tb/tb_testeio_dual_port_ram_pl.sv
// Directed bench: one RAM at READ_LATENCY=1 and one at 2 receive identical stimulus.
module tb_testeio_dual_port_ram_pl;

  localparam int          DW = 32;
  localparam int          AW = 4;
  localparam logic [31:0] IV = 32'hA5A5_5A5A;

  logic clk;
  logic reset_n;
  logic done_a, done_b;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp5 [8];

  testeio_dual_port_ram_pl_if #(.DATA_W(DW), .ADDR_W(AW)) a1 ();
  testeio_dual_port_ram_pl_if #(.DATA_W(DW), .ADDR_W(AW)) a2 ();
  testeio_dual_port_ram_pl_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  testeio_dual_port_ram_pl_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();

  testeio_dual_port_ram_pl #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .INIT_ON_RESET(1), .INIT_VALUE(IV)
  ) u_l1 (.clk(clk), .reset_n(reset_n), .s1(a1.slave), .s2(a2.slave), .init_done(done_a));

  testeio_dual_port_ram_pl #(
    .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .INIT_ON_RESET(1), .INIT_VALUE(IV)
  ) u_l2 (.clk(clk), .reset_n(reset_n), .s1(b1.slave), .s2(b2.slave), .init_done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv1(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] ad,
                      input logic [3:0] be, input logic [31:0] wd);
    a1.chipselect = cs; a1.read = rd; a1.write = wr; a1.address = ad; a1.byteenable = be; a1.writedata = wd;
    b1.chipselect = cs; b1.read = rd; b1.write = wr; b1.address = ad; b1.byteenable = be; b1.writedata = wd;
  endtask

  task automatic drv2(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] ad,
                      input logic [3:0] be, input logic [31:0] wd);
    a2.chipselect = cs; a2.read = rd; a2.write = wr; a2.address = ad; a2.byteenable = be; a2.writedata = wd;
    b2.chipselect = cs; b2.read = rd; b2.write = wr; b2.address = ad; b2.byteenable = be; b2.writedata = wd;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdata_l1"}, 64'({a1.readdata, a2.readdata}), 64'h0);
    chk({tag, "_rdata_l2"}, 64'({b1.readdata, b2.readdata}), 64'h0);
    chk({tag, "_ctrl"},
        64'({a1.readdatavalid, a2.readdatavalid, b1.readdatavalid, b2.readdatavalid,
             a1.waitrequest, a2.waitrequest, b1.waitrequest, b2.waitrequest, done_a, done_b}),
        64'b0000_1111_00);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_busy"},
          64'({a1.waitrequest, a2.waitrequest, b1.waitrequest, b2.waitrequest, done_a, done_b}),
          64'b1111_00);
      step();
    end
    chk({tag, "_ready"},
        64'({a1.waitrequest, a2.waitrequest, b1.waitrequest, b2.waitrequest, done_a, done_b}),
        64'b0000_11);
  endtask

  initial begin
    exp5[0] = IV; exp5[1] = IV; exp5[2] = IV; exp5[3] = 32'h2222_2222;
    exp5[4] = IV; exp5[5] = 32'hDEAD_BEAA; exp5[6] = IV; exp5[7] = 32'hCAFE_BABE;
    reset_n = 1'b0;
    drv1(0, 0, 0, 0, 0, 0);
    drv2(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk_reset("rst0");
    reset_n = 1'b1;

    // power-up clear and read-back of every address
    wait_init("init1");
    for (int i = 0; i < 16; i++) begin
      drv1(1, 1, 0, AW'(i), 0, 0);
      step();
      chk("t1_rd_l1", 64'({a1.readdatavalid, a1.readdata}), 64'({1'b1, IV}));
      if (i > 0) chk("t1_rd_l2", 64'({b1.readdatavalid, b1.readdata}), 64'({1'b1, IV}));
    end
    drv1(0, 0, 0, 0, 0, 0);
    step();
    chk("t1_last_l2", 64'({b1.readdatavalid, b1.readdata}), 64'({1'b1, IV}));
    chk("t1_idle_l1", 64'(a1.readdatavalid), 64'd0);

    // partial byte write then cross-port read, latency 1 vs 2
    drv1(1, 0, 1, 4'h5, 4'hF, 32'hDEAD_BEEF);
    step();
    drv1(1, 0, 1, 4'h5, 4'h1, 32'h0000_00AA);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    drv2(1, 1, 0, 4'h5, 0, 0);
    step();
    drv2(0, 0, 0, 0, 0, 0);
    chk("t2_l1_valid", 64'({a2.readdatavalid, a2.readdata}), 64'({1'b1, 32'hDEAD_BEAA}));
    chk("t2_l2_early", 64'(b2.readdatavalid), 64'd0);
    step();
    chk("t2_l1_hold", 64'({a2.readdatavalid, a2.readdata}), 64'({1'b0, 32'hDEAD_BEAA}));
    chk("t2_l2_valid", 64'({b2.readdatavalid, b2.readdata}), 64'({1'b1, 32'hDEAD_BEAA}));

    // write/write collision: s2 stalled one cycle, retry lands last
    drv1(1, 0, 1, 4'h3, 4'hF, 32'h1111_1111);
    drv2(1, 0, 1, 4'h3, 4'hF, 32'h2222_2222);
    #1;
    chk("t3_stall", 64'({a1.waitrequest, a2.waitrequest, b1.waitrequest, b2.waitrequest}), 64'b0101);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    #1;
    chk("t3_retry", 64'({a1.waitrequest, a2.waitrequest, b1.waitrequest, b2.waitrequest}), 64'b0000);
    step();
    drv2(0, 0, 0, 0, 0, 0);
    drv1(1, 1, 0, 4'h3, 0, 0);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    chk("t3_rd_l1", 64'({a1.readdatavalid, a1.readdata}), 64'({1'b1, 32'h2222_2222}));
    step();
    chk("t3_rd_l2", 64'({b1.readdatavalid, b1.readdata}), 64'({1'b1, 32'h2222_2222}));

    // read-during-write forwarding of enabled bytes only
    drv1(1, 0, 1, 4'h7, 4'hF, 32'h0000_BABE);
    step();
    drv1(1, 0, 1, 4'h7, 4'hC, 32'hCAFE_0000);
    drv2(1, 1, 0, 4'h7, 0, 0);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    drv2(0, 0, 0, 0, 0, 0);
    chk("t4_fwd_l1", 64'({a2.readdatavalid, a2.readdata}), 64'({1'b1, 32'hCAFE_BABE}));
    step();
    chk("t4_fwd_l2", 64'({b2.readdatavalid, b2.readdata}), 64'({1'b1, 32'hCAFE_BABE}));
    chk("t4_hold_l1", 64'({a2.readdatavalid, a2.readdata}), 64'({1'b0, 32'hCAFE_BABE}));
    drv1(1, 1, 0, 4'h7, 0, 0);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    chk("t4_array", 64'({a1.readdatavalid, a1.readdata}), 64'({1'b1, 32'hCAFE_BABE}));
    step();

    // read+write together: write wins, no readdatavalid; be=0 write is a no-op
    drv2(1, 1, 1, 4'h8, 4'hF, 32'h1234_5678);
    step();
    drv2(0, 0, 0, 0, 0, 0);
    chk("rw_drop_l1", 64'(a2.readdatavalid), 64'd0);
    step();
    chk("rw_drop_l2", 64'(b2.readdatavalid), 64'd0);
    drv2(1, 1, 0, 4'h8, 0, 0);
    step();
    drv2(0, 0, 0, 0, 0, 0);
    chk("rw_written", 64'({a2.readdatavalid, a2.readdata}), 64'({1'b1, 32'h1234_5678}));
    drv1(1, 0, 1, 4'h8, 4'h0, 32'hFFFF_FFFF);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    drv2(1, 1, 0, 4'h8, 0, 0);
    step();
    drv2(0, 0, 0, 0, 0, 0);
    chk("be0_noop", 64'({a2.readdatavalid, a2.readdata}), 64'({1'b1, 32'h1234_5678}));
    step();

    // back-to-back reads 0..7
    for (int i = 0; i < 8; i++) begin
      drv2(1, 1, 0, AW'(i), 0, 0);
      step();
      chk("t5_l1", 64'({a2.readdatavalid, a2.readdata}), 64'({1'b1, exp5[i]}));
      if (i > 0) chk("t5_l2", 64'({b2.readdatavalid, b2.readdata}), 64'({1'b1, exp5[i-1]}));
    end
    drv2(0, 0, 0, 0, 0, 0);
    step();
    chk("t5_l2_last", 64'({b2.readdatavalid, b2.readdata}), 64'({1'b1, exp5[7]}));
    chk("t5_l1_idle", 64'(a2.readdatavalid), 64'd0);
    step();
    chk("t5_l2_hold", 64'({b2.readdatavalid, b2.readdata}), 64'({1'b0, exp5[7]}));

    // reset, then reset again mid-clear at clr_addr=9
    reset_n = 1'b0;
    #1;
    chk_reset("rst1");
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("t6_busy", 64'({a1.waitrequest, a2.waitrequest, done_a, done_b}), 64'b1100);
      step();
    end
    reset_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    step();
    reset_n = 1'b1;
    wait_init("init2");
    drv1(1, 1, 0, 4'h5, 0, 0);
    step();
    drv1(0, 0, 0, 0, 0, 0);
    chk("t6_clr_l1", 64'({a1.readdatavalid, a1.readdata}), 64'({1'b1, IV}));
    step();
    chk("t6_clr_l2", 64'({b1.readdatavalid, b1.readdata}), 64'({1'b1, IV}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
